// File: rtl/conv_tile_responder_if.sv
// Bus bundle between the conv controller / SRAM / PE array and the tile responder.
// The responder takes the slave side; the surrounding environment drives the master side.
interface conv_tile_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
);
    logic                  transmission_start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic                  busy;
    logic                  transmission_done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport slave (
        input  transmission_start, start_addr, length, mem_rd_data, out_ready,
        output busy, transmission_done, mem_rd_en, mem_addr, out_valid, out_data, out_last
    );

    modport master (
        output transmission_start, start_addr, length, mem_rd_data, out_ready,
        input  busy, transmission_done, mem_rd_en, mem_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_tile_responder.sv
// Streams `length` SRAM words starting at `start_addr` to the PE array over valid/ready,
// using a 2-entry skid FIFO to cover the fixed 1-cycle SRAM read latency.
module conv_tile_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_tile_responder_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state;
    logic [LEN_WIDTH-1:0]  reads_left;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  busy_q;
    logic                  done_q;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;

    assign push = vld_p1;
    assign pop  = (fifo_count != 2'd0) && bus.out_ready;

    // Buffered plus in-flight words after this cycle's pop must leave room for one more.
    assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
    assign issue     = (state == FETCH) && (reads_left != '0) && (occupancy < 3'd2);

    assign bus.mem_rd_en         = issue;
    assign bus.mem_addr          = addr_p0;
    assign bus.out_valid         = (fifo_count != 2'd0);
    assign bus.out_data          = fifo_mem[rd_ptr];
    assign bus.out_last          = (fifo_count != 2'd0) && (beats_left == LEN_ONE);
    assign bus.busy              = busy_q;
    assign bus.transmission_done = done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            reads_left <= '0;
            beats_left <= '0;
            addr_p0    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (pop) begin
                beats_left <= beats_left - LEN_ONE;
            end
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.transmission_start) begin
                        addr_p0    <= bus.start_addr;
                        reads_left <= bus.length;
                        beats_left <= bus.length;
                        if (bus.length == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= FETCH;
                            busy_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        addr_p0    <= addr_p0 + ADDR_ONE;
                        reads_left <= reads_left - LEN_ONE;
                        if (reads_left == LEN_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (beats_left == LEN_ONE)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // p1: read issued last cycle, SRAM word is on mem_rd_data and lands in the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            vld_p1 <= issue;
            if (push) begin
                fifo_mem[wr_ptr] <= bus.mem_rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: doc/conv_tile_responder.md
Name: conv_tile_responder

Overview:
- Responder side of the conv controller's transmission handshake.
- The controller FSM raises transmission_start together with a base address and beat count. This block then reads that many words from on-chip feature/weight SRAM (1-cycle read latency). It streams them to the PE array over a valid/ready interface and pulses transmission_done when the last beat is accepted.
- A 2-entry skid FIFO absorbs backpressure against the fixed read latency.

Parameters:
- DATA_WIDTH, 16, width of one SRAM word / stream beat
- ADDR_WIDTH, 12, SRAM address width
- LEN_WIDTH, 12, width of the beat-count field

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- transmission_start  in  1  request from controller FSM; level or pulse, sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first SRAM address; captured with transmission_start
- length  in  LEN_WIDTH  number of beats; captured with transmission_start
- busy  out  1  high from the cycle after acceptance until transmission_done is asserted
- transmission_done  out  1  one-cycle completion pulse
- mem_rd_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_WIDTH  SRAM read address
- mem_rd_data  in  DATA_WIDTH  SRAM data; valid the cycle after mem_rd_en
- out_valid  out  1  stream beat valid
- out_data  out  DATA_WIDTH  stream beat data
- out_last  out  1  high on the final beat of a transfer
- out_ready  in  1  PE array accepts a beat when out_valid and out_ready are both high

Behaviour:
- Reset (rst=0 at an edge):
  - state goes to IDLE and the FIFO and in-flight flag are cleared.
  - busy, transmission_done, mem_rd_en, out_valid and out_last are 0; mem_addr and out_data are 0.
  - Reset mid-transfer aborts the transfer with no done pulse; SRAM data returning afterwards is discarded.
- States:
  - IDLE: on transmission_start=1, capture start_addr/length. If length==0, go to DONE; otherwise go to FETCH.
  - FETCH: issue reads until `length` reads have been issued, then go to DRAIN.
  - DRAIN: wait until all beats are accepted. On acceptance of the last beat, go to DONE.
  - DONE: assert transmission_done for exactly one cycle, then go to IDLE. busy=0 in DONE.
- Read issue rule: mem_rd_en=1 in a cycle iff all of the following hold:
  - state is FETCH
  - reads remaining > 0
  - (fifo_count + inflight − pop_this_cycle) < 2
- mem_addr increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH.
- inflight is set the cycle after mem_rd_en. The returning mem_rd_data is pushed into the FIFO at the next edge.
- Stream side:
  - out_valid = (fifo_count > 0); out_data is the FIFO head.
  - Data is held stable while out_valid=1 and out_ready=0.
  - out_last=1 only with the beat whose index equals length−1.
- Push and pop in the same cycle are legal; the count is unchanged.
- The FIFO never overflows, by construction of the issue rule. The bench asserts this.
- Latency: transmission_start sampled at edge E0.
  - mem_rd_en=1 during cycle E0→E1; data pushed at E2; out_valid=1 from E2.
  - With out_ready held 1: one beat per cycle, and the last beat is accepted at E(length+1).
  - transmission_done is high in the cycle following that acceptance.
- transmission_start while busy or in DONE is ignored; it is not queued.
- length==0: DONE is reached the cycle after acceptance, with no reads and no beats.
- Beat counters are LEN_WIDTH wide. A length of all-ones (4095) must complete correctly.

Test Plan:
- Reset check: rst=0 for 3 cycles with transmission_start=1 -> all outputs 0, busy stays 0, no mem_rd_en.
- Basic streaming:
  - Stimulus: start_addr=0x010, length=4, out_ready=1, SRAM[a]=a+0x100.
  - Expected: out_data 0x110,0x111,0x112,0x113 on consecutive cycles; out_last only on 0x113; transmission_done one cycle after; busy high throughout.
- Backpressure:
  - Stimulus: length=6, out_ready toggling 1,0,0,1,…
  - Expected: beats in order, none lost or duplicated; out_data stable while stalled; at most 2 reads outstanding plus buffered.
- Zero length and wrap:
  - length=0 -> transmission_done pulse with no beats and no mem_rd_en.
  - start_addr=0xFFE, length=3 -> addresses 0xFFE, 0xFFF, 0x000.
- Reset mid-transfer:
  - Stimulus: length=8, rst=0 after 3 beats are accepted.
  - Expected: outputs cleared next edge, no transmission_done. A new start with length=2 then completes cleanly.
- Ignored restart:
  - Stimulus: pulse transmission_start again during a length=5 transfer.
  - Expected: exactly 5 beats and one transmission_done pulse.
